// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the 4x4 RAM built-in self-test.
package ram_bist_pkg;

  localparam int unsigned DefaultDataW = 4;
  localparam int unsigned DefaultAddrW = 2;
  localparam int unsigned ERR_MAX      = 7;

  typedef enum logic {
    DirUp,
    DirDown
  } dir_e;

  typedef enum logic [3:0] {
    StIdle,
    StW0,
    StR0Req,
    StR0Wait,
    StR0Cmp,
    StR1Req,
    StR1Wait,
    StR1Cmp,
    StFin
  } bist_state_e;

endpackage

// File: rtl/bist_cmp.sv
// Registered read check: first-fail capture and saturating mismatch counter.
module bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              check_en,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] actual,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        err_count
);

  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [2:0]        err_count_q;
  logic              mismatch;

  assign mismatch = check_en && (actual != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_count_q <= '0;
    end else if (clear) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_count_q <= '0;
    end else if (mismatch) begin
      // A zero count means no earlier mismatch in this run.
      if (err_count_q == '0) begin
        fail_addr_q <= addr;
        fail_data_q <= actual;
      end
      if (err_count_q != 3'(ERR_MAX)) begin
        err_count_q <= err_count_q + 3'd1;
      end
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/ram_4x4_bist.sv
// March-test initiator for the 4x4 RAM: up(w P); up(r P, w ~P); down(r ~P).
module ram_4x4_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned       DATA_W       = DefaultDataW,
  parameter int unsigned       ADDR_W       = DefaultAddrW,
  parameter logic [DATA_W-1:0] PATTERN      = 4'b1010,
  parameter int unsigned       READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        err_count
);

  localparam logic [ADDR_W-1:0] AddrLast = '1;

  function automatic logic [ADDR_W-1:0] step_addr(logic [ADDR_W-1:0] a, dir_e dir);
    return (dir == DirDown) ? a - ADDR_W'(1) : a + ADDR_W'(1);
  endfunction

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic              clear;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              pass_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StW0;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      StW0: begin
        if (cnt_q == AddrLast) begin
          state_d = StR0Req;
          cnt_d   = '0;
        end else begin
          cnt_d = step_addr(cnt_q, DirUp);
        end
      end
      StR0Req: begin
        wait_d  = 2'd1;
        state_d = (READ_LATENCY > 1) ? StR0Wait : StR0Cmp;
      end
      StR0Wait: begin
        if (wait_q == 2'(READ_LATENCY - 1)) state_d = StR0Cmp;
        else wait_d = wait_q + 2'd1;
      end
      StR0Cmp: begin
        if (cnt_q == AddrLast) begin
          state_d = StR1Req;
          cnt_d   = AddrLast;
        end else begin
          state_d = StR0Req;
          cnt_d   = step_addr(cnt_q, DirUp);
        end
      end
      StR1Req: begin
        wait_d  = 2'd1;
        state_d = (READ_LATENCY > 1) ? StR1Wait : StR1Cmp;
      end
      StR1Wait: begin
        if (wait_q == 2'(READ_LATENCY - 1)) state_d = StR1Cmp;
        else wait_d = wait_q + 2'd1;
      end
      StR1Cmp: begin
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          state_d = StR1Req;
          cnt_d   = step_addr(cnt_q, DirDown);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM port is registered from the next state so it lines up with the state it belongs to.
  always_comb begin
    ram_en_d   = 1'b0;
    ram_addr_d = '0;
    ram_din_d  = '0;
    unique case (state_d)
      StW0: begin
        ram_en_d   = 1'b1;
        ram_addr_d = cnt_d;
        ram_din_d  = PATTERN;
      end
      StR0Cmp: begin
        ram_en_d   = 1'b1;
        ram_addr_d = cnt_d;
        ram_din_d  = ~PATTERN;
      end
      StR0Req, StR0Wait, StR1Req, StR1Wait, StR1Cmp: ram_addr_d = cnt_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wait_q     <= '0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      if (clear) pass_q <= 1'b0;
      else if (state_q == StFin) pass_q <= (err_count == '0);
    end
  end

  bist_cmp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .check_en ((state_q == StR0Cmp) || (state_q == StR1Cmp)),
    .expected ((state_q == StR0Cmp) ? PATTERN : ~PATTERN),
    .actual   (ram_dout),
    .addr     (cnt_q),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .err_count(err_count)
  );

  assign ram_en   = ram_en_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = (state_q != StIdle) && (state_q != StFin);
  assign done     = (state_q == StFin);
  // The final count settles on entry to FIN, so show it live there and hold it afterwards.
  assign pass     = (state_q == StFin) ? (err_count == '0) : pass_q;

endmodule

// File: tb/tb_ram_4x4_bist.sv
// Directed bench for ram_4x4_bist with behavioural RAM models and fault injection.
module tb_ram_4x4_bist;

  logic       clk = 1'b0;
  logic       rst_n, start, start2;
  logic       ram_en, ram_en2;
  logic [1:0] ram_addr, ram_addr2, fail_addr, fail_addr2;
  logic [3:0] ram_din, ram_din2, ram_dout, ram_dout2, fail_data, fail_data2;
  logic       busy, busy2, done, done2, pass, pass2;
  logic [2:0] err_count, err_count2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_4x4_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count)
  );

  ram_4x4_bist #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .ram_en(ram_en2), .ram_addr(ram_addr2),
    .ram_din(ram_din2), .ram_dout(ram_dout2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail_addr2), .fail_data(fail_data2), .err_count(err_count2)
  );

  // RAM models: latency 1 with per-address stuck-at masks, and a clean latency-2 RAM.
  logic [3:0] mem [4];
  logic [3:0] mem2 [4];
  logic [3:0] and_mask [4];
  logic [3:0] or_mask [4];
  logic [3:0] pipe2 [2];
  logic [3:0] rd1;
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      mem[ram_addr] <= ram_din;
      wr_cnt <= wr_cnt + 1;
    end
    rd1 <= (mem[ram_addr] & and_mask[ram_addr]) | or_mask[ram_addr];
    if (ram_en2) mem2[ram_addr2] <= ram_din2;
    pipe2[0] <= mem2[ram_addr2];
    pipe2[1] <= pipe2[0];
  end
  assign ram_dout  = rd1;
  assign ram_dout2 = pipe2[1];

  logic [6:0] trace [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 4; i++) begin
      and_mask[i] = 4'hF;
      or_mask[i]  = 4'h0;
    end
  endtask

  // Called at a negedge; c counts edges since start was sampled.
  task automatic run(input bit sel, input int re_a, input int re_b,
                     output int busy_n, output int done_at, output int done_n);
    busy_n = 0; done_at = -1; done_n = 0;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (sel ? busy2 : busy) busy_n++;
      if (sel ? done2 : done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (c <= 4) trace[c] = {ram_en, ram_addr, ram_din};
      start = (c == re_a || c == re_b);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int bn, da, dn, wr_snap;

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    clear_faults();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 4'h0; mem2[i] = 4'h0;
    end
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({ram_en, ram_addr, ram_din, busy, done, pass, fail_addr,
                             fail_data, err_count}), 0);
    check("reset_outs2", 32'({busy2, done2, pass2, err_count2, ram_en2}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run
    run(1'b0, 0, 0, bn, da, dn);
    check("clean_busy_cycles", bn, 20);
    check("clean_done_cycle", da, 21);
    check("clean_done_pulses", dn, 1);
    check("clean_pass", 32'(pass), 1);
    check("clean_err", 32'(err_count), 0);
    for (int a = 0; a < 4; a++) begin
      logic [6:0] exp_tr;
      exp_tr = {1'b1, 2'(a), 4'b1010};
      check($sformatf("w0_trace_%0d", a), 32'(trace[a+1]), 32'(exp_tr));
    end

    // Addr 2 bit 0 stuck-at-1
    or_mask[2] = 4'b0001;
    run(1'b0, 0, 0, bn, da, dn);
    check("sa1_busy_cycles", bn, 20);
    check("sa1_pass", 32'(pass), 0);
    check("sa1_fail_addr", 32'(fail_addr), 2);
    check("sa1_fail_data", 32'(fail_data), 32'hB);
    check("sa1_err", 32'(err_count), 1);
    clear_faults();

    // Every cell reads 0000
    for (int i = 0; i < 4; i++) and_mask[i] = 4'h0;
    run(1'b0, 0, 0, bn, da, dn);
    check("sa0_pass", 32'(pass), 0);
    check("sa0_err_sat", 32'(err_count), 7);
    check("sa0_fail_addr", 32'(fail_addr), 0);
    check("sa0_fail_data", 32'(fail_data), 0);
    clear_faults();

    // start re-pulsed mid-run
    run(1'b0, 3, 15, bn, da, dn);
    check("restart_busy_cycles", bn, 20);
    check("restart_done_cycle", da, 21);
    check("restart_done_pulses", dn, 1);
    check("restart_pass", 32'(pass), 1);
    check("restart_err", 32'(err_count), 0);

    // Reset in the middle of R0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_was_busy", 32'(busy), 1);
    wr_snap = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({ram_en, ram_addr, ram_din, busy, done, pass, fail_addr,
                              fail_data, err_count}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_writes", wr_cnt, wr_snap);
    run(1'b0, 0, 0, bn, da, dn);
    check("postrst_busy_cycles", bn, 20);
    check("postrst_pass", 32'(pass), 1);
    check("postrst_err", 32'(err_count), 0);

    // READ_LATENCY=2 instance
    run(1'b1, 0, 0, bn, da, dn);
    check("rl2_busy_cycles", bn, 28);
    check("rl2_done_cycle", da, 29);
    check("rl2_pass", 32'(pass2), 1);
    check("rl2_err", 32'(err_count2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_4x4_bist.md
Name: ram_4x4_bist

Overview:
Built-in self-test initiator for the 4x4 RAM: the controller side of the RAM's `en`/`addr`/`din`/`dout` interface. On a start pulse it drives a 3-phase march sequence into the RAM and checks every read against the expected pattern. It reports pass/fail, the first failing address and data, and an error count. It sits beside the RAM and shares its clock; production logic owns the RAM port when `busy`=0, through an external mux.

Parameters:
- DATA_W, 4, RAM data width
- ADDR_W, 2, RAM address width (depth = 2**ADDR_W)
- PATTERN, 4'b1010, background pattern P; the complement ~P is the second pattern
- READ_LATENCY, 1, cycles from a read request (`en`=0, `addr` driven) to valid `dout`; legal range 1..3

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run the test; sampled only in IDLE
- ram_en  out  1  RAM write enable (1 = write, 0 = read/no-op)
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  1 = last completed test had zero mismatches
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_data  out  DATA_W  data read at the first mismatch
- err_count  out  3  number of mismatches, saturating at 7

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0 (`ram_en`, `ram_addr`, `ram_din`, `busy`, `done`, `pass`, `fail_addr`, `fail_data`, `err_count`). The FSM returns to IDLE.
- Reset mid-test: aborts immediately, with no further RAM writes.
- RAM contract: a write occurs at the rising edge while `ram_en`=1. A read is requested by holding `ram_en`=0 with `ram_addr` for one cycle; `ram_dout` is sampled READ_LATENCY cycles later.
- `ram_en`=1 only in write cycles. All RAM outputs are registered.
- FSM states: IDLE, W0, R0_REQ, R0_WAIT, R0_CMP, R1_REQ, R1_WAIT, R1_CMP, FIN.
- IDLE: RAM outputs 0. When `start`=1 at an edge:
  - clear `pass`, `fail_addr`, `fail_data`, `err_count`;
  - set `busy`=1;
  - set address counter to 0;
  - go to W0.
- `start` is ignored in every non-IDLE state.
- W0 (ascending, up(w P)): one cycle per address with `ram_en`=1, `ram_din`=P, addresses 0..3. After address 3, reset the counter to 0 and go to R0_REQ.
- R0 (ascending, up(r P, w ~P)):
  - R0_REQ: `ram_en`=0, `ram_addr`=counter.
  - R0_WAIT: held for READ_LATENCY-1 cycles; skipped when READ_LATENCY=1.
  - R0_CMP: compare `ram_dout` with P while driving `ram_en`=1, `ram_din`=~P at the same address.
  - After address 3, set counter to 3 and go to R1_REQ.
- R1 (descending, down(r ~P)): same REQ/WAIT/CMP flow with `ram_en`=0 throughout. Compare against ~P. Addresses run 3..0.
- Mismatch in any CMP state:
  - `err_count` increments, saturating at 7;
  - if this is the first mismatch of the run, latch `fail_addr`=counter and `fail_data`=`ram_dout`;
  - the test continues; there is no early abort.
- Address counter: ADDR_W bits. The phase exit is decided on the terminal value (3 ascending, 0 descending), never on wrap-around.
- FIN: lasts one cycle.
  - `busy`=0.
  - `done`=1 for exactly this cycle.
  - `pass`=(`err_count`==0), held until the next start.
  - Return to IDLE.
- Busy duration: 4 + 8*(1+READ_LATENCY) cycles, which is 20 at the defaults. `done` rises on the cycle after the last CMP.
- `start` arriving in the same cycle as FIN is ignored. A new run needs `start` in IDLE.

Decomposition:
- Shared package ram_bist_pkg holds:
  - the state enum;
  - the DATA_W/ADDR_W defaults;
  - the phase direction constants;
  - the saturation limit ERR_MAX=7.
- One sub-module, bist_cmp: registered compare plus first-fail capture plus saturating error counter. It has inputs `check_en`, `expected`, `actual` and `addr`, and outputs `fail_addr`, `fail_data` and `err_count`.
- FSM and address counter stay in the top-level module.

Test Plan:
- Fault-free behavioural RAM, `start` pulse → `busy` high for exactly 20 cycles; W0 trace shows `ram_en`=1 and `ram_din`=1010 at addresses 0,1,2,3; `done` pulses once; `pass`=1; `err_count`=0.
- Addr 2 bit 0 stuck-at-1 → R0 reads 1011 at addr 2 (mismatch); R1 reads 0101 (match); result `pass`=0, `fail_addr`=2, `fail_data`=1011, `err_count`=1.
- All cells stuck at 0000 → 8 mismatches; `err_count` saturates at 7; `fail_addr`=0; `fail_data`=0000.
- `start` re-pulsed at cycles 3 and 15 of a run → no restart; `done` occurs at the original cycle count; results unchanged.
- `rst_n` asserted mid-R0 → all outputs 0 immediately; no write occurs after reset; a new `start` then runs a full clean test with `pass`=1.
- READ_LATENCY=2 with a matching RAM model → `busy` lasts 28 cycles; `pass`=1; each compare samples `dout` 2 cycles after its request.
